pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM generator. One shared prescaler and period counter drive CHANNELS independent comparators. Each comparator has a double-buffered duty register that updates only at a period boundary. Supports edge-aligned and center-aligned modes. Sits between the control/register logic and the motor/LED drive pins, and is the generalised successor of the single-channel 11-bit free-running PWM.

## Interface

**Parameters**
- WIDTH, 11 — counter, period and duty width.
- CHANNELS, 4 — number of PWM outputs; must be ≥ 1.
- PRESCALE_W, 8 — prescaler compare width.
- CH_W, $clog2(CHANNELS) (minimum 1) — channel select width.

**Ports**
- clk_in — in — 1 — single clock, rising edge.
- rst — in — 1 — asynchronous, active-high reset.
- enable — in — 1 — 1 = run, 0 = hold.
- mode — in — 1 — 0 = edge-aligned, 1 = center-aligned.
- period — in — WIDTH — terminal count.
- prescale — in — PRESCALE_W — a tick occurs every prescale+1 clocks.
- wr_en — in — 1 — duty write strobe.
- wr_ch — in — CH_W — channel written; out-of-range values are ignored.
- wr_duty — in — WIDTH — duty value to load into the shadow register.
- pwm_out — out — CHANNELS — registered PWM outputs.
- period_tick — out — 1 — one-clock pulse at each period boundary.

## Operation

**Reset (rst = 1, asynchronous)**
- Clears the prescaler, counter, dir (up), every shadow duty, every active duty, pwm_out and period_tick to 0.

**Prescaler**
- Counts 0..prescale.
- Asserts an internal tick in the cycle where it equals prescale, then returns to 0.
- With prescale = 0, a tick occurs every clock.

**Edge mode (mode = 0), on each tick**
- If counter ≥ period: counter ← 0 and a boundary occurs.
- Otherwise: counter ← counter + 1.
- Period length is period + 1 ticks.

**Center mode (mode = 1), on each tick**
- Up direction: if counter ≥ period, then dir ← down and counter ← period − 1; otherwise counter + 1.
- Down direction: counter − 1. When counter is 1, the next value is 0, dir ← up, and a boundary occurs.
- Period length is 2·period ticks.
- period = 0 behaves as edge mode (counter stuck at 0, boundary every tick).

**Duty buffering**
- wr_en writes wr_duty into shadow[wr_ch] on the next clock.
- At a boundary, active[i] ← shadow[i] for all channels.
- If a write coincides with a boundary, active takes the pre-write shadow value; the new value applies at the following boundary.

**Compare, every clock**
- pwm_out[i] ← (counter < active[i]).
- duty 0 gives a constant 0.
- duty > period gives a constant 1 in edge mode.
- Center mode gives a symmetric pulse of width 2·duty − 1 ticks, for duty ≤ period.

**period_tick**
- Registered 1 for exactly one clock in the cycle after the boundary tick.

**enable = 0**
- Prescaler and counter are held at 0, dir is up, and pwm_out is 0.
- active[i] follows shadow[i] every clock.
- Writes are still accepted.

**Run start**
- On 0→1 of enable, counting starts from 0; the first tick occurs prescale + 1 clocks later.

**Changing period or mode while running**
- Takes effect immediately.
- The ≥ comparisons guarantee recovery within one tick if counter exceeds the new period.
- A mode change while dir = down forces dir ← up and counter ← 0, which counts as a boundary.

## Timing

- **Output latency:** pwm_out reflects the counter value of the previous clock (1-clock latency); all outputs are registered.
- **Write-to-output latency:** the worst case is one full period plus 2 clocks.
- **Tick spacing:** with prescale = P, the counter changes every P + 1 clocks.
- **Reset release:** the first rising clk_in edge after rst deasserts operates normally.
- **Reset mid-period:** outputs go to 0 immediately (asynchronous), with no glitch to 1.

## Test plan

1. **Reset values.** Assert rst mid-run with pwm_out = 4'b1111 → pwm_out = 0 and period_tick = 0 immediately. After release with enable = 1, period = 9, prescale = 0, the counter starts at 0.
2. **Edge mode, prescale 0.** WIDTH = 11, period = 9, duty ch0 = 3, ch1 = 0, ch2 = 10, ch3 = 2047; load while disabled, then enable → ch0 is high 3 of every 10 clocks, ch1 is always low, ch2 and ch3 are always high. period_tick pulses every 10 clocks.
3. **Prescaler.** prescale = 2, period = 4, duty ch0 = 2 → period_tick every 15 clocks; ch0 high for 6 clocks per period.
4. **Double buffering.** Running at period = 9, write ch0 = 7 mid-period → the current period keeps the old duty of 3. The next period is high for 7 clocks. A write issued in the boundary-tick cycle is deferred one more period.
5. **Center mode.** mode = 1, period = 5, duty = 2, prescale = 0 → period_tick every 10 clocks; ch0 high for 3 consecutive clocks, centered on counter = 0.
6. **Boundary changes.** Reduce period from 20 to 5 while counter = 12 → the counter wraps to 0 on the next tick. Toggle enable to 0 mid-period → all outputs go to 0 on the next clock and the counter returns to 0.

Source files
------------

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control, duty-write and output bundle for pwm_multi
// master drives enable/mode/period/prescale and duty writes; slave returns pwm_out/period_tick
interface pwm_multi_if #(
  parameter int WIDTH = 11,
  parameter int CHANNELS = 4,
  parameter int PRESCALE_W = 8,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic enable;
  logic mode;
  logic [WIDTH-1:0] period;
  logic [PRESCALE_W-1:0] prescale;
  logic wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [WIDTH-1:0] wr_duty;
  logic [CHANNELS-1:0] pwm_out;
  logic period_tick;
  modport master (
    output enable, mode, period, prescale, wr_en, wr_ch, wr_duty,
    input pwm_out, period_tick
  );
  modport slave (
    input enable, mode, period, prescale, wr_en, wr_ch, wr_duty,
    output pwm_out, period_tick
  );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared prescaler/counter and double-buffered duties
// clk_in/rst: clock and async active-high reset; bus: control inputs, duty writes, pwm_out, period_tick
module pwm_multi #(
  parameter int WIDTH = 11,
  parameter int CHANNELS = 4,
  parameter int PRESCALE_W = 8,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic clk_in,
  input logic rst,
  pwm_multi_if.slave bus
);
  logic [PRESCALE_W-1:0] pre;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic dir, dir_nxt, bnd, tick;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic [CHANNELS-1:0] pwm_q;
  logic tick_q;
  assign tick = bus.enable && pre == bus.prescale;
  assign bus.pwm_out = pwm_q;
  assign bus.period_tick = tick_q;
  // dir = 1 means counting down; a leftover down state in edge mode (or period 0) snaps back to 0 as a boundary
  always_comb begin
    cnt_nxt = cnt + WIDTH'(1);
    dir_nxt = dir;
    bnd = 1'b0;
    if (!bus.mode || bus.period == '0) begin
      if (dir || cnt >= bus.period) begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        bnd = 1'b1;
      end
    end else if (!dir) begin
      if (cnt >= bus.period) begin
        cnt_nxt = bus.period - WIDTH'(1);
        dir_nxt = bus.period != WIDTH'(1);
        bnd = bus.period == WIDTH'(1);
      end
    end else if (cnt <= WIDTH'(1)) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
      bnd = 1'b1;
    end else begin
      cnt_nxt = cnt - WIDTH'(1);
    end
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
      dir <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pre <= (!bus.enable || tick) ? '0 : pre + PRESCALE_W'(1);
      cnt <= !bus.enable ? '0 : tick ? cnt_nxt : cnt;
      dir <= bus.enable && (tick ? dir_nxt : dir);
      tick_q <= tick && bnd;
    end
  end
  // active copies the pre-write shadow, so a write landing on a boundary waits one more period
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (bus.wr_en && 32'(bus.wr_ch) < CHANNELS) shadow[bus.wr_ch] <= bus.wr_duty;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!bus.enable || (tick && bnd)) active[i] <= shadow[i];
        pwm_q[i] <= bus.enable && cnt < active[i];
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
module tb_pwm_multi;
  logic clk_in = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  int hi [4];
  int ticks, first, maxrun;
  always #5 clk_in = ~clk_in;
  pwm_multi_if bus ();
  pwm_multi dut (.clk_in(clk_in), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic run(input int n);
    int cur = 0;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ticks = 0;
    first = 0;
    maxrun = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_in);
      for (int c = 0; c < 4; c++) if (bus.pwm_out[c]) hi[c]++;
      cur = bus.pwm_out[0] ? cur + 1 : 0;
      if (cur > maxrun) maxrun = cur;
      if (bus.period_tick) begin
        ticks++;
        if (first == 0) first = k;
      end
    end
  endtask
  task automatic wr(input logic [1:0] ch, input logic [10:0] d);
    bus.wr_en = 1'b1;
    bus.wr_ch = ch;
    bus.wr_duty = d;
    @(negedge clk_in);
    bus.wr_en = 1'b0;
  endtask
  task automatic start();
    @(negedge clk_in);
    bus.enable = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.mode = 1'b0;
    bus.period = 11'd9;
    bus.prescale = 8'd0;
    bus.wr_en = 1'b0;
    bus.wr_ch = 2'd0;
    bus.wr_duty = 11'd0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    chk("reset_pwm", int'(bus.pwm_out), 0);
    chk("reset_tick", int'(bus.period_tick), 0);
    wr(2'd0, 11'd3);
    wr(2'd1, 11'd0);
    wr(2'd2, 11'd10);
    wr(2'd3, 11'd2047);
    start();
    run(30);
    chk("edge_ch0_hi", hi[0], 9);
    chk("edge_ch1_hi", hi[1], 0);
    chk("edge_ch2_hi", hi[2], 30);
    chk("edge_ch3_hi", hi[3], 30);
    chk("edge_ticks", ticks, 3);
    chk("edge_first_tick", first, 10);
    run(3);
    wr(2'd0, 11'd7);
    run(6);
    chk("dbuf_old_duty", hi[0], 0);
    run(10);
    chk("dbuf_new_duty", hi[0], 7);
    run(9);
    wr(2'd0, 11'd1);
    run(10);
    chk("dbuf_bnd_deferred", hi[0], 7);
    run(10);
    chk("dbuf_bnd_applied", hi[0], 1);
    bus.enable = 1'b0;
    bus.prescale = 8'd2;
    bus.period = 11'd4;
    wr(2'd0, 11'd2);
    start();
    run(45);
    chk("pre_ticks", ticks, 3);
    chk("pre_first_tick", first, 15);
    chk("pre_ch0_hi", hi[0], 18);
    chk("pre_ch0_run", maxrun, 6);
    bus.enable = 1'b0;
    bus.prescale = 8'd0;
    bus.mode = 1'b1;
    bus.period = 11'd5;
    wr(2'd0, 11'd2);
    start();
    run(30);
    chk("ctr_ticks", ticks, 3);
    chk("ctr_first_tick", first, 10);
    chk("ctr_ch0_hi", hi[0], 9);
    chk("ctr_ch0_run", maxrun, 3);
    chk("ctr_ch1_hi", hi[1], 0);
    bus.enable = 1'b0;
    bus.mode = 1'b0;
    bus.period = 11'd20;
    wr(2'd0, 11'd15);
    start();
    run(12);
    bus.period = 11'd5;
    run(1);
    chk("shrink_wrap_tick", ticks, 1);
    run(6);
    chk("shrink_ticks", ticks, 1);
    chk("shrink_first_tick", first, 6);
    chk("shrink_ch0_hi", hi[0], 6);
    run(2);
    bus.enable = 1'b0;
    run(1);
    chk("disable_pwm", int'(bus.pwm_out), 0);
    chk("disable_tick", int'(bus.period_tick), 0);
    start();
    run(6);
    chk("reenable_first_tick", first, 6);
    bus.enable = 1'b0;
    wr(2'd0, 11'd2047);
    wr(2'd1, 11'd2047);
    start();
    run(3);
    chk("all_high", int'(bus.pwm_out), 15);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", int'(bus.pwm_out), 0);
    chk("async_rst_tick", int'(bus.period_tick), 0);
    bus.period = 11'd9;
    @(negedge clk_in);
    rst = 1'b0;
    run(10);
    chk("post_rst_first_tick", first, 10);
    chk("post_rst_ch2_hi", hi[2], 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
